// File: rtl/pq_cmd_sequencer.sv
// Command sequencer in front of the priority queue: buffers enq/deq requests in a
// small FIFO and issues them one at a time. Optional statistics counters: PQ_SEQ_STATS_EN.
module pq_cmd_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              cmd_kv,
    input  logic                     cmd_enq,
    input  logic                     cmd_deq,
    output logic [15:0]              pq_kvi,
    output logic                     pq_enq,
    output logic                     pq_deq,
    input  logic                     pq_busy,
    input  logic                     pq_full,
    input  logic                     pq_empty,
    input  logic [15:0]              pq_kvo,
    output logic [15:0]              kvo_hold,
    output logic                     kvo_valid,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     idle,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         rej_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT
    } state_t;

    state_t            state_reg, state_next;
    logic [16:0]       fifo_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     cnt_reg;
    logic [15:0]       kvi_reg;
    logic              enq_reg, deq_reg;
    logic [15:0]       kvo_hold_reg;
    logic              kvo_valid_reg;

    logic              fifo_full;
    logic              push_req;
    logic              push;
    logic [16:0]       push_entry;
    logic [16:0]       head;
    logic              head_reject;
    logic              pop;
    logic              start_issue;
    logic              reject;

    // Entry layout {op, kv}; op=1 marks a DEQ, whose kv is stored as zero.
    assign fifo_full   = (cnt_reg == CW'(DEPTH));
    assign push_req    = cmd_enq | cmd_deq;
    assign push        = push_req & ~fifo_full;
    assign push_entry  = cmd_enq ? {1'b0, cmd_kv} : {1'b1, 16'h0000};
    assign head        = fifo_mem[rd_ptr_reg];
    assign head_reject = head[16] ? pq_empty : pq_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_reg <= cnt_reg + CW'(1);
                2'b01:   cnt_reg <= cnt_reg - CW'(1);
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A popped command is either rejected on the spot or handed to ISSUE.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        start_issue = 1'b0;
        reject      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cnt_reg != '0 && !pq_busy) begin
                    pop = 1'b1;
                    if (head_reject) begin
                        reject = 1'b1;
                    end else begin
                        start_issue = 1'b1;
                        state_next  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_next = ST_GUARD;
            // PQ may raise busy one cycle after the pulse, so skip one cycle.
            ST_GUARD: state_next = ST_WAIT;
            ST_WAIT: begin
                if (!pq_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pulses are registered so they coincide exactly with the ISSUE state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kvi_reg       <= '0;
            enq_reg       <= 1'b0;
            deq_reg       <= 1'b0;
            kvo_hold_reg  <= '0;
            kvo_valid_reg <= 1'b0;
        end else begin
            enq_reg <= start_issue & ~head[16];
            deq_reg <= start_issue &  head[16];
            if (start_issue) begin
                kvi_reg <= head[15:0];
            end
            if (state_reg == ST_ISSUE && deq_reg) begin
                kvo_hold_reg  <= pq_kvo;
                kvo_valid_reg <= 1'b1;
            end
        end
    end

    assign pq_kvi    = kvi_reg;
    assign pq_enq    = enq_reg;
    assign pq_deq    = deq_reg;
    assign kvo_hold  = kvo_hold_reg;
    assign kvo_valid = kvo_valid_reg;
    assign fifo_cnt  = cnt_reg;
    assign idle      = (cnt_reg == '0) && (state_reg == ST_IDLE);

`ifdef PQ_SEQ_STATS_EN
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] ovf_reg, rej_reg;
    logic [1:0]       ovf_inc;
    logic [CNT_W:0]   ovf_sum, rej_sum;

    // A colliding pair arriving at a full FIFO loses both commands.
    always_comb begin
        ovf_inc = {1'b0, cmd_enq & cmd_deq} + {1'b0, push_req & fifo_full};
        ovf_sum = {1'b0, ovf_reg} + {{(CNT_W-1){1'b0}}, ovf_inc};
        rej_sum = {1'b0, rej_reg} + {{CNT_W{1'b0}}, reject};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= '0;
            rej_reg <= '0;
        end else begin
            ovf_reg <= (ovf_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : ovf_sum[CNT_W-1:0];
            rej_reg <= (rej_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : rej_sum[CNT_W-1:0];
        end
    end

    assign ovf_cnt = ovf_reg;
    assign rej_cnt = rej_reg;
`else
    assign ovf_cnt = '0;
    assign rej_cnt = '0;
`endif

endmodule
